// File: rtl/port_arb_pkg.sv
// port_arb_pkg: shared types and constants for the two-port memory arbiter.
package port_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic INST = 1'b0;
    localparam logic DATA = 1'b1;
    localparam int TIMEOUT_CYCLES_DEF = 1024;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick; grant is the port ID (0 = INST, 1 = DATA).
module rr_arbiter2 (
    input  logic i_req_inst,
    input  logic i_req_data,
    input  logic i_last_grant,
    output logic o_grant
);
    assign o_grant = (i_req_inst & i_req_data) ? ~i_last_grant : i_req_data;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between instruction and data ports.
module mem_port_arbiter import port_arb_pkg::*; #(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        inst_req_i,
    input  logic        inst_wren_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] inst_data_i,
    output logic        inst_done_o,
    output logic [31:0] inst_data_o,
    input  logic        data_req_i,
    input  logic        data_wren_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_data_i,
    output logic        data_done_o,
    output logic [31:0] data_data_o,
    output logic        mem_req_o,
    output logic        mem_wren_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic        mem_done_i,
    input  logic [31:0] mem_data_i,
    output logic        timeout_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
    state_t      r_state;
    logic        r_last;
    logic        r_owner;
    logic        r_mem_req;
    logic        r_mem_wren;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_data;
    logic [CW-1:0] r_cnt;
    logic        r_inst_done;
    logic        r_data_done;
    logic        r_timeout;
    logic [31:0] r_inst_data;
    logic [31:0] r_data_data;
    logic        w_grant;
    logic        w_expire;
    logic        w_load;
    logic [31:0] w_rdata;
    rr_arbiter2 u_rr (
        .i_req_inst  (inst_req_i),
        .i_req_data  (data_req_i),
        .i_last_grant(r_last),
        .o_grant     (w_grant)
    );
    // A real completion wins over the limit; a timeout always overwrites the owner's data.
    assign w_expire = (r_cnt == LIMIT);
    assign w_rdata  = mem_done_i ? mem_data_i : ERR_DATA;
    assign w_load   = mem_done_i ? ~r_mem_wren : 1'b1;
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= IDLE;
            r_last      <= INST;
            r_owner     <= INST;
            r_mem_req   <= 1'b0;
            r_mem_wren  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_cnt       <= '0;
            r_inst_done <= 1'b0;
            r_data_done <= 1'b0;
            r_timeout   <= 1'b0;
            r_inst_data <= '0;
            r_data_data <= '0;
        end else begin
            r_inst_done <= 1'b0;
            r_data_done <= 1'b0;
            r_timeout   <= 1'b0;
            case (r_state)
                IDLE: if (inst_req_i || data_req_i) begin
                    r_state    <= BUSY;
                    r_owner    <= w_grant;
                    r_last     <= w_grant;
                    r_cnt      <= '0;
                    r_mem_req  <= 1'b1;
                    r_mem_wren <= (w_grant == DATA) ? data_wren_i : inst_wren_i;
                    r_mem_addr <= (w_grant == DATA) ? data_addr_i : inst_addr_i;
                    r_mem_data <= (w_grant == DATA) ? data_data_i : inst_data_i;
                end
                BUSY: if (mem_done_i || w_expire) begin
                    r_state     <= DONE;
                    r_mem_req   <= 1'b0;
                    r_mem_wren  <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_data  <= '0;
                    r_timeout   <= ~mem_done_i;
                    r_inst_done <= (r_owner == INST);
                    r_data_done <= (r_owner == DATA);
                    if (w_load && r_owner == INST) r_inst_data <= w_rdata;
                    if (w_load && r_owner == DATA) r_data_data <= w_rdata;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign inst_done_o = r_inst_done;
    assign data_done_o = r_data_done;
    assign inst_data_o = r_inst_data;
    assign data_data_o = r_data_data;
    assign mem_req_o   = r_mem_req;
    assign mem_wren_o  = r_mem_wren;
    assign mem_addr_o  = r_mem_addr;
    assign mem_data_o  = r_mem_data;
    assign timeout_o   = r_timeout;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench with a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int T = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;
    typedef struct {
        logic        port;
        logic        wren;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        bit          first;
        int          rise;
        logic [31:0] ei;
        logic [31:0] ed;
    } txn_t;
    typedef struct {
        int          cyc;
        logic        port;
        logic        to;
        logic [31:0] ei;
        logic [31:0] ed;
    } done_t;
    typedef struct {
        int          dly;
        logic [31:0] rdata;
    } resp_t;
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic inst_req_i = 1'b0, inst_wren_i = 1'b0, data_req_i = 1'b0, data_wren_i = 1'b0;
    logic [31:0] inst_addr_i = '0, inst_data_i = '0, data_addr_i = '0, data_data_i = '0;
    logic mem_done_i = 1'b0;
    logic [31:0] mem_data_i = '0;
    logic inst_done_o, data_done_o, mem_req_o, mem_wren_o, timeout_o;
    logic [31:0] inst_data_o, data_data_o, mem_addr_o, mem_data_o;
    mem_port_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clock_i(clk), .reset_i(reset_i),
        .inst_req_i(inst_req_i), .inst_wren_i(inst_wren_i), .inst_addr_i(inst_addr_i),
        .inst_data_i(inst_data_i), .inst_done_o(inst_done_o), .inst_data_o(inst_data_o),
        .data_req_i(data_req_i), .data_wren_i(data_wren_i), .data_addr_i(data_addr_i),
        .data_data_i(data_data_i), .data_done_o(data_done_o), .data_data_o(data_data_o),
        .mem_req_o(mem_req_o), .mem_wren_o(mem_wren_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_done_i(mem_done_i), .mem_data_i(mem_data_i),
        .timeout_o(timeout_o)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;
    int n_cmp = 0, n_bad = 0, rises = 0, dones = 0;
    txn_t  txn_q[$];
    done_t done_q[$];
    resp_t resp_q[$];
    // Reference model: peripheral memory, last port granted, each port's visible read data.
    logic [31:0] mem_m [logic [31:0]];
    logic        m_last = 1'b0;
    logic [31:0] m_inst_d = '0, m_data_d = '0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask
    task automatic summary_and_finish();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask
    task automatic abort(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no response within budget at cycle %0d", nm, cyc);
        summary_and_finish();
    endtask
    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem_m.exists(a) ? mem_m[a] : (a ^ 32'h5A5A_A5A5);
    endfunction
    function automatic logic [31:0] rand_addr();
        return ($urandom % 4 == 0) ? 32'h0400_0010 : 32'h100 + 32'($urandom % 8) * 4;
    endfunction
    function automatic int rand_dly();
        int r;
        r = int'($urandom % 8);
        return (r == 6) ? T - 1 : (r == 7) ? T + 3 : r % 4;
    endfunction
    task automatic add_txn(input logic p, input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input int dly, input bit first, input int rise);
        txn_t t;
        resp_t r;
        logic to;
        logic [31:0] rdat;
        to = (dly >= T);
        rdat = w ? $urandom : rd_mem(a);
        if (!to && w) mem_m[a] = wd;
        if (to) begin
            if (p) m_data_d = ERR; else m_inst_d = ERR;
        end else if (!w) begin
            if (p) m_data_d = rdat; else m_inst_d = rdat;
        end
        m_last = p;
        t.port = p; t.wren = w; t.addr = a; t.wdata = wd; t.dly = dly;
        t.first = first; t.rise = rise; t.ei = m_inst_d; t.ed = m_data_d;
        txn_q.push_back(t);
        r.dly = dly; r.rdata = rdat;
        resp_q.push_back(r);
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            if (txn_q.size() == 0 && done_q.size() == 0) return;
            @(negedge clk); #1;
        end
        abort("wait_idle");
    endtask
    task automatic wait_rise(input int target);
        for (int i = 0; i < 80; i++) begin
            if (rises >= target) return;
            @(negedge clk); #1;
        end
        abort("wait_grant");
    endtask
    task automatic wait_done(input int target);
        for (int i = 0; i < 80; i++) begin
            if (dones >= target) return;
            @(negedge clk); #1;
        end
        abort("wait_done");
    endtask
    task automatic drop(input logic p);
        if (p) begin
            data_req_i = 0; data_wren_i = $urandom; data_addr_i = $urandom; data_data_i = $urandom;
        end else begin
            inst_req_i = 0; inst_wren_i = $urandom; inst_addr_i = $urandom; inst_data_i = $urandom;
        end
    endtask
    task automatic run_round(input bit ui, input bit ud, input logic iw, input logic dw,
                             input logic [31:0] ia, input logic [31:0] idt,
                             input logic [31:0] da, input logic [31:0] ddt,
                             input int idl, input int ddl, input bit ih, input bit dh);
        int p0, br, bd, n;
        logic g [2];
        wait_idle();
        @(posedge clk); #1;
        p0 = cyc;
        n = (ui && ud) ? 2 : 1;
        g[0] = (ui && ud) ? ~m_last : ud;
        g[1] = ~g[0];
        for (int k = 0; k < n; k++)
            if (g[k]) add_txn(1'b1, dw, da, ddt, ddl, k == 0, p0 + 1);
            else      add_txn(1'b0, iw, ia, idt, idl, k == 0, p0 + 1);
        inst_req_i = ui; inst_wren_i = iw; inst_addr_i = ia; inst_data_i = idt;
        data_req_i = ud; data_wren_i = dw; data_addr_i = da; data_data_i = ddt;
        br = rises;
        bd = dones;
        for (int k = 0; k < n; k++) begin
            wait_rise(br + k + 1);
            if (g[k] ? dh : ih) wait_done(bd + k + 1);
            drop(g[k]);
        end
    endtask
    task automatic run_random();
        int m;
        m = int'($urandom % 3);
        run_round(m != 1, m != 0, 1'($urandom), 1'($urandom), rand_addr(), $urandom,
                  rand_addr(), $urandom, rand_dly(), rand_dly(), 1'($urandom), 1'($urandom));
    endtask
    task automatic run_hold(input int n);
        int p0, br;
        logic [31:0] a;
        wait_idle();
        @(posedge clk); #1;
        p0 = cyc;
        a = rand_addr();
        for (int k = 0; k < n; k++) add_txn(1'b0, 1'b0, a, 32'h0, int'($urandom % 3), k == 0, p0 + 1);
        inst_req_i = 1; inst_wren_i = 0; inst_addr_i = a; inst_data_i = 0;
        br = rises;
        wait_rise(br + n);
        drop(1'b0);
    endtask
    task automatic chk_all_zero(input string nm);
        chk({nm, "_mem_req"}, mem_req_o, 0);
        chk({nm, "_mem_wren"}, mem_wren_o, 0);
        chk({nm, "_mem_addr"}, mem_addr_o, 0);
        chk({nm, "_mem_data"}, mem_data_o, 0);
        chk({nm, "_inst_done"}, inst_done_o, 0);
        chk({nm, "_data_done"}, data_done_o, 0);
        chk({nm, "_inst_data"}, inst_data_o, 0);
        chk({nm, "_data_data"}, data_data_o, 0);
        chk({nm, "_timeout"}, timeout_o, 0);
    endtask
    // Downstream responder: completes after the scripted delay, adds stray done pulses when idle.
    int r_cnt;
    bit r_arm = 0, r_prev = 0, r_spill = 0;
    logic [31:0] r_dat;
    resp_t rr;
    always @(negedge clk) begin
        if (reset_i) begin
            mem_done_i = 0; r_arm = 0; r_prev = 0; r_spill = 0;
        end else begin
            mem_done_i = 0;
            mem_data_i = $urandom;
            if (r_spill || (!mem_req_o && $urandom % 8 == 0)) mem_done_i = 1;
            r_spill = 0;
            if (mem_req_o && !r_prev && resp_q.size() != 0) begin
                rr = resp_q.pop_front();
                r_arm = (rr.dly < T);
                r_cnt = rr.dly;
                r_dat = rr.rdata;
            end
            if (r_arm && mem_req_o) begin
                if (r_cnt == 0) begin
                    mem_done_i = 1; mem_data_i = r_dat; r_arm = 0; r_spill = 1'($urandom);
                end else r_cnt--;
            end
            r_prev = mem_req_o;
        end
    end
    // Downstream monitor: checks each grant's order, timing and held request fields.
    txn_t mt;
    done_t md;
    bit m_prev = 0;
    int last_done = 0, er;
    always @(negedge clk) begin
        if (reset_i) m_prev = 0;
        else begin
            if (mem_req_o && !m_prev) begin
                if (txn_q.size() == 0) chk("unexpected_grant", 1, 0);
                else begin
                    mt = txn_q.pop_front();
                    er = mt.first ? mt.rise : last_done + 2;
                    chk("grant_cycle", cyc, er);
                    chk("grant_wren", mem_wren_o, mt.wren);
                    chk("grant_addr", mem_addr_o, mt.addr);
                    chk("grant_data", mem_data_o, mt.wdata);
                    last_done = er + ((mt.dly < T) ? mt.dly : T - 1) + 1;
                    md.cyc = last_done; md.port = mt.port; md.to = (mt.dly >= T);
                    md.ei = mt.ei; md.ed = mt.ed;
                    done_q.push_back(md);
                    rises++;
                end
            end else if (mem_req_o) begin
                chk("busy_wren_stable", mem_wren_o, mt.wren);
                chk("busy_addr_stable", mem_addr_o, mt.addr);
                chk("busy_data_stable", mem_data_o, mt.wdata);
            end else begin
                chk("idle_mem_wren", mem_wren_o, 0);
                chk("idle_mem_addr", mem_addr_o, 0);
                chk("idle_mem_data", mem_data_o, 0);
            end
            m_prev = mem_req_o;
        end
    end
    // Completion monitor: compares each done pulse with the scoreboard.
    done_t dd;
    always @(negedge clk) begin
        if (!reset_i) begin
            if (inst_done_o || data_done_o) begin
                if (done_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    dd = done_q.pop_front();
                    chk("done_port", {30'b0, data_done_o, inst_done_o}, dd.port ? 32'd2 : 32'd1);
                    chk("done_cycle", cyc, dd.cyc);
                    chk("done_timeout", timeout_o, dd.to);
                    chk("inst_data", inst_data_o, dd.ei);
                    chk("data_data", data_data_o, dd.ed);
                    dones++;
                end
            end else chk("timeout_without_done", timeout_o, 0);
        end
    end
    initial begin
        mem_m[32'h100] = 32'h12345678;
        #3;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #2 reset_i = 0;
        run_round(1, 0, 0, 0, 32'h100, 0, 0, 0, 2, 0, 1, 0);
        run_round(1, 1, 0, 1, 32'h200, 0, 32'h300, 32'hAA, 1, 1, 0, 0);
        run_round(0, 1, 0, 1, 0, 0, 32'h0400_0010, 32'hCAFE_F00D, 0, 0, 0, 1);
        run_round(1, 0, 0, 0, 32'h104, 0, 0, 0, T + 3, 0, 1, 0);
        run_round(1, 0, 0, 0, 32'h100, 0, 0, 0, T - 1, 0, 0, 0);
        run_hold(3);
        repeat (40) run_random();
        wait_idle();
        @(posedge clk); #1;
        add_txn(1'b0, 1'b0, 32'h108, 0, 5, 1'b1, cyc + 1);
        inst_req_i = 1; inst_wren_i = 0; inst_addr_i = 32'h108; inst_data_i = 0;
        wait_rise(rises + 1);
        @(negedge clk); #2;
        reset_i = 1;
        #1;
        chk_all_zero("midbusy_reset");
        inst_req_i = 0;
        txn_q.delete(); done_q.delete(); resp_q.delete();
        m_last = 0; m_inst_d = 0; m_data_d = 0;
        repeat (2) @(posedge clk);
        #2 reset_i = 0;
        repeat (4) @(negedge clk);
        #1 chk("post_reset_no_grant", mem_req_o, 0);
        run_round(1, 1, 0, 0, 32'h100, 0, 32'h104, 0, 0, 2, 0, 0);
        repeat (20) run_random();
        wait_idle();
        repeat (3) @(posedge clk);
        summary_and_finish();
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have one clock and asynchronous, active-high reset: clock_i, reset_i.
REQ-002 SHALL take parameter TIMEOUT_CYCLES, default 1024: downstream cycles allowed before forced completion.
REQ-003 clock_i  input  1  rising-edge clock.
REQ-004 reset_i  input  1  asynchronous active-high reset.
REQ-005 inst_req_i, inst_wren_i  input  1 each  instruction-port request and write enable.
REQ-006 inst_addr_i, inst_data_i  input  32 each  instruction-port address and write data.
REQ-007 inst_done_o  output  1; inst_data_o  output  32: completion pulse and read data.
REQ-008 data_req_i, data_wren_i, data_addr_i, data_data_i, data_done_o, data_data_o: same widths and meanings, data port.
REQ-009 mem_req_o, mem_wren_o  output  1; mem_addr_o, mem_data_o  output  32: shared downstream port feeding the address-decode switch.
REQ-010 mem_done_i  input  1; mem_data_i  input  32: downstream completion and read data.
REQ-011 timeout_o  output  1: one-cycle pulse on forced completion.

Function
REQ-012 SHALL use FSM states IDLE, BUSY, DONE.
REQ-013 In IDLE, if any req_i is high, SHALL grant one port and latch its wren/addr/data into registers; next state BUSY.
REQ-014 Single requester SHALL be granted. Both requesting: grant the port not granted last (round-robin). last_grant resets to INST, so the first tie goes to DATA.
REQ-015 In BUSY, mem_req_o SHALL be 1 and mem_wren/addr/data_o SHALL drive the latched values. In IDLE and DONE, all mem_*_o SHALL be 0.
REQ-016 In BUSY, when mem_done_i=1, SHALL register mem_data_i into the owner's data register; next state DONE.
REQ-017 mem_done_i SHALL be accepted in the first BUSY cycle (zero-wait peripherals).
REQ-018 In DONE, SHALL assert the owner's done_o for exactly one cycle; the other port's done_o SHALL stay 0.
REQ-019 DONE SHALL return to IDLE unconditionally. Requests SHALL NOT be sampled in DONE, so a req held through the done pulse is not re-granted.
REQ-020 Latency: req sampled at cycle 0, mem_req_o high at cycle 1; if mem_done_i is at cycle k, done_o is at cycle k+1. Back-to-back grants are no closer than 3 cycles apart.
REQ-021 inst_data_o and data_data_o SHALL hold their last completed value until that port's next completion. Writes SHALL leave data_o unchanged.
REQ-022 Timeout counter (width clog2(TIMEOUT_CYCLES)+1):
  - cleared on entry to BUSY; increments each BUSY cycle without mem_done_i.
  - on reaching TIMEOUT_CYCLES: go to DONE, load owner data with 32'hDEADBEEF, pulse timeout_o with the done pulse.
  - mem_done_i in the same cycle as the limit takes precedence; no timeout.
REQ-023 A requester dropping req while in BUSY SHALL NOT abort the transaction. It completes from latched values and done_o still pulses.
REQ-024 Input changes during BUSY SHALL NOT affect mem_*_o.
REQ-025 mem_done_i in IDLE or DONE SHALL be ignored.

Reset
REQ-026 reset_i SHALL immediately force:
  - state IDLE, last_grant INST, counter 0;
  - every output 0, including both data_o registers.
REQ-027 Reset mid-BUSY SHALL drop the transaction silently: no done_o pulse, and no re-issue after release.
REQ-028 First grant SHALL occur no earlier than the first rising edge after reset_i deasserts.

Structure
REQ-029 Shared package port_arb_pkg SHALL hold:
  - state enum (IDLE/BUSY/DONE);
  - port-ID constants (INST=0, DATA=1);
  - TIMEOUT_CYCLES default;
  - 32'hDEADBEEF error constant.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter2 (two requests, last_grant in, grant out). Everything else SHALL stay in mem_port_arbiter.

Verification
REQ-031 inst_req=1, read addr 0x100, mem_done_i 2 cycles after mem_req_o with data 0x12345678 -> mem_addr_o=0x100; inst_done_o pulses one cycle later; inst_data_o=0x12345678.
REQ-032 Both ports request in the same cycle after reset -> DATA granted first, then INST; done pulses 3+ cycles apart.
REQ-033 Data write addr 0x04000010 (peripheral), mem_done_i high in the first BUSY cycle -> data_done_o exactly 2 cycles after the request is sampled; data_data_o unchanged.
REQ-034 TIMEOUT_CYCLES=8, mem_done_i never asserted -> after 8 BUSY cycles, owner done_o and timeout_o pulse together; data_o=0xDEADBEEF; next request served normally.
REQ-035 reset_i asserted in the 2nd BUSY cycle -> all outputs 0 asynchronously; no done_o; next request after release gets a fresh grant.
REQ-036 inst_req held high continuously -> one grant per completion; no duplicate grant during the DONE cycle.
